// File: rtl/rr_mux4_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter_pkg
// Shared definitions for the round-robin 4:1 mux arbiter.
//   N_REQ   : number of requesters sharing the output path
//   SEL_W   : width of the owner index / mux select
//   state_t : controller state (IDLE = nobody owns the path)
//   rr_pick : round-robin winner search starting after 'last'
//   onehot  : index -> one-hot grant vector
// ---------------------------------------------------------------------------
package rr_mux4_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Scan last+1, last+2, ... wrapping mod N_REQ; 'last' itself is scanned
  // at the very end, so the current owner only wins when alone.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4x1.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter_mux4x1
// One-bit 4:1 multiplexer cell of the shared datapath.
//   d0..d3 : data inputs
//   s1, s0 : select, {s1,s0} = index of the forwarded input
//   y      : selected data
// ---------------------------------------------------------------------------
module rr_mux4_arbiter_mux4x1 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  assign y = s1 ? (s0 ? d3 : d2) : (s0 ? d1 : d0);

endmodule

// File: rtl/rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter
// Round-robin arbiter that shares one 4:1 multiplexed path between four
// requesters, limiting how long one owner can hold the path under contention.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req[3:0]   : request lines, bit i = requester i wants the path
//   in0..in3   : requester data, DATA_W bits each
//   grant[3:0] : registered one-hot grant, zero when idle
//   sel1, sel0 : registered mux select (owner index), held while idle
//   out        : granted requester's data, zero when idle
//   busy       : registered, high while a requester owns the path
// Parameters: DATA_W data width; MAX_HOLD (1..255) max consecutive cycles an
// owner keeps the path while someone else is waiting.
// ---------------------------------------------------------------------------
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [N_REQ-1:0]  grant,
  output logic              sel1,
  output logic              sel0,
  output logic [DATA_W-1:0] out,
  output logic              busy
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            state, state_n;
  logic [N_REQ-1:0]  grant_n;
  logic [SEL_W-1:0]  sel, sel_n;
  logic [SEL_W-1:0]  last, last_n;
  logic [7:0]        hold_cnt, hold_n;
  logic [N_REQ-1:0]  others;
  logic [SEL_W-1:0]  winner;
  logic [DATA_W-1:0] mux_bits;

  // Reset leaves last=3 so requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      last     <= SEL_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      last     <= last_n;
      hold_cnt <= hold_n;
    end
  end

  // The owner is always 'last', so rr_pick scanning from last naturally
  // excludes the owner whenever anyone else is requesting; this covers
  // both the release hand-over and the forced rotation.
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    last_n  = last;
    hold_n  = hold_cnt;
    others  = req & ~grant;
    winner  = rr_pick(req, last);

    unique case (state)
      IDLE: begin
        if (req != '0) begin
          state_n = GRANT;
          grant_n = onehot(winner);
          sel_n   = winner;
          last_n  = winner;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!req[last]) begin
          if (others != '0) begin
            grant_n = onehot(winner);
            sel_n   = winner;
            last_n  = winner;
            hold_n  = '0;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            hold_n  = '0;
          end
        end else if (others != '0) begin
          if (hold_cnt >= HOLD_LAST) begin
            grant_n = onehot(winner);
            sel_n   = winner;
            last_n  = winner;
            hold_n  = '0;
          end else begin
            hold_n  = hold_cnt + 8'd1;
          end
        end else begin
          // Alone on the path: count up to the limit and sit there so a
          // newcomer gets the path at the very next edge.
          hold_n = (hold_cnt >= HOLD_LAST) ? HOLD_LAST : hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  assign sel1 = sel[1];
  assign sel0 = sel[0];
  assign busy = (state == GRANT);

  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    rr_mux4_arbiter_mux4x1 u_mux (
      .d0 (in0[b]),
      .d1 (in1[b]),
      .d2 (in2[b]),
      .d3 (in3[b]),
      .s1 (sel1),
      .s0 (sel0),
      .y  (mux_bits[b])
    );
  end

  // sel holds its last value while idle, so the path is gated off by grant.
  assign out = mux_bits & {DATA_W{|grant}};

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux4_arbiter
// Directed bench for rr_mux4_arbiter: instance 'a' with MAX_HOLD=4 and a
// 4-bit datapath, instance 'b' with MAX_HOLD=1 and a 1-bit datapath.
// ---------------------------------------------------------------------------
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] req_a = '0;
  logic [3:0] in0_a, in1_a, in2_a, in3_a;
  logic [3:0] grant_a;
  logic       sel1_a, sel0_a, busy_a;
  logic [3:0] out_a;

  logic [3:0] req_b = '0;
  logic       in0_b = 1'b1, in1_b = 1'b0, in2_b = 1'b1, in3_b = 1'b0;
  logic [3:0] grant_b;
  logic       sel1_b, sel0_b, busy_b;
  logic       out_b;

  logic [3:0] data_a [4] = '{4'hA, 4'h3, 4'h5, 4'hC};

  int n_asserts = 0;
  int n_fail    = 0;

  assign in0_a = data_a[0];
  assign in1_a = data_a[1];
  assign in2_a = data_a[2];
  assign in3_a = data_a[3];

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.DATA_W(4), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .in0(in0_a), .in1(in1_a), .in2(in2_a), .in3(in3_a),
    .grant(grant_a), .sel1(sel1_a), .sel0(sel0_a), .out(out_a), .busy(busy_a)
  );

  rr_mux4_arbiter #(.DATA_W(1), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .in0(in0_b), .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .grant(grant_b), .sel1(sel1_b), .sel0(sel0_b), .out(out_b), .busy(busy_b)
  );

  // Request lines must never carry X into the arbiter.
  always @(posedge clk) begin
    if ($isunknown({req_a, req_b})) begin
      n_fail++;
      $error("[TB] FAIL req_x: observed %b_%b required known", req_a, req_b);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // Expected values for instance a: grant, sel index, busy; out derived
  // from the bench's own data table.
  task automatic checkA(input string tag, input logic [3:0] g,
                        input logic [1:0] s, input logic b);
    logic [3:0] o;
    o = (g != 4'b0) ? data_a[s] : 4'h0;
    checkOutput({tag, ".grant"}, 32'(grant_a), 32'(g));
    checkOutput({tag, ".sel"},   32'({sel1_a, sel0_a}), 32'(s));
    checkOutput({tag, ".busy"},  32'(busy_a), 32'(b));
    checkOutput({tag, ".out"},   32'(out_a), 32'(o));
  endtask

  task automatic checkB(input string tag, input logic [3:0] g,
                        input logic [1:0] s, input logic o);
    checkOutput({tag, ".grant"}, 32'(grant_b), 32'(g));
    checkOutput({tag, ".sel"},   32'({sel1_b, sel0_b}), 32'(s));
    checkOutput({tag, ".out"},   32'(out_b), 32'(o));
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] ra,
                               input logic [3:0] rb);
    rst   = r;
    req_a = ra;
    req_b = rb;
  endtask

  initial begin
    logic [1:0] idx;

    // Reset, then idle with no requests.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    checkA("reset", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      checkA("idle", 4'b0000, 2'd0, 1'b0);
    end

    // Single requester 2, held, then released.
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step();
      checkA("solo2", 4'b0100, 2'd2, 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    step();
    checkA("release2", 4'b0000, 2'd2, 1'b0);

    // Full contention from reset: each owner keeps the path 4 cycles.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    for (int k = 0; k < 17; k++) begin
      step();
      idx = 2'((k / 4) % 4);
      checkA("rot4", 4'b0001 << idx, idx, 1'b1);
    end

    // Owner 1 releases while 0 and 3 wait: hand over to 3 without a gap.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    step();
    checkA("own1", 4'b0010, 2'd1, 1'b1);
    applyStimulus(1'b0, 4'b1001, 4'b0000);
    step();
    checkA("handover3", 4'b1000, 2'd3, 1'b1);

    // Owner 3 releases to 1, then idle; new 0+2 from last=1 must pick 2.
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    step();
    checkA("handover1", 4'b0010, 2'd1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    step();
    checkA("idle_last1", 4'b0000, 2'd1, 1'b0);
    applyStimulus(1'b0, 4'b0101, 4'b0000);
    step();
    checkA("rr_from1", 4'b0100, 2'd2, 1'b1);

    // Saturated hold: once 2 has been alone long enough, a newcomer wins
    // at the very next edge.
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      checkA("sat2", 4'b0100, 2'd2, 1'b1);
    end
    applyStimulus(1'b0, 4'b0101, 4'b0000);
    step();
    checkA("sat_rotate", 4'b0001, 2'd0, 1'b1);

    // Reset during a grant, then re-arbitration from last=3.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    step();
    checkA("pre_rst", 4'b0100, 2'd2, 1'b1);
    applyStimulus(1'b0, 4'b0110, 4'b0000);
    step();
    checkA("pre_rst2", 4'b0100, 2'd2, 1'b1);
    applyStimulus(1'b1, 4'b0110, 4'b0000);
    step();
    checkA("mid_rst", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b0110, 4'b0000);
    step();
    checkA("post_rst", 4'b0010, 2'd1, 1'b1);

    // MAX_HOLD=1: two requesters alternate every cycle.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    step();
    checkB("b_reset", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0011);
    for (int k = 0; k < 6; k++) begin
      step();
      idx = 2'(k % 2);
      checkB("b_alt", 4'b0001 << idx, idx, (idx == 2'd0) ? in0_b : in1_b);
    end

    // MAX_HOLD=1, sole requester 2 keeps the path indefinitely.
    applyStimulus(1'b0, 4'b0000, 4'b0100);
    for (int k = 0; k < 6; k++) begin
      step();
      checkB("b_solo2", 4'b0100, 2'd2, in2_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
